// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for ram_port_arbiter: two requester ports, the RAM macro pins and statistics.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface ram_port_arbiter_if;
  logic        reqA;
  logic        weA;
  logic [7:0]  addrA;
  logic [15:0] wdataA;
  logic        ackA;
  logic        reqB;
  logic        weB;
  logic [7:0]  addrB;
  logic [15:0] wdataB;
  logic        ackB;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  ramAddr;
  logic [15:0] ramWriteData;
  logic        ramWriteEn;
  logic        ramCLK;
  logic        ramCLKEn;
  logic [15:0] ramReadData;
  logic [7:0]  conflictCount;

  modport slave (
    input  reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, ramReadData,
    output ackA, ackB, rdata, busy, ramAddr, ramWriteData, ramWriteEn,
           ramCLK, ramCLKEn, conflictCount
  );

  modport master (
    output reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, ramReadData,
    input  ackA, ackB, rdata, busy, ramAddr, ramWriteData, ramWriteEn,
           ramCLK, ramCLKEn, conflictCount
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one 256x16 RAM port between requesters A and B, generating a full registered RAM cycle per grant.
// Optional contention counter enabled by defining RAM_ARB_STATS_EN.
module ram_port_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int HIGH_CYCLES   = 1
) (
  input  logic             clock,
  input  logic             resetn,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] HC_LAST = 4'(HIGH_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_hcnt;
  logic [3:0]  w_hcnt_nxt;
  logic        r_gnt_b;
  logic        r_last_b;
  logic        w_gnt_b;
  logic        w_any_req;
  logic        w_conflict;
  logic        w_grant;
  logic        w_sel_we;
  logic [7:0]  w_sel_addr;
  logic [15:0] w_sel_wdata;

  logic        r_ackA;
  logic        r_ackB;
  logic [15:0] r_rdata;
  logic        r_busy;
  logic [7:0]  r_ram_addr;
  logic [15:0] r_ram_wdata;
  logic        r_ram_we;
  logic        r_ram_clk;
  logic        r_ram_clken;

  // Arbitration: tie goes to the requester that was not granted last, or always to A in fixed mode
  always_comb begin
    w_any_req  = bus.reqA | bus.reqB;
    w_conflict = bus.reqA & bus.reqB;
    if (PRIORITY_MODE != 0) begin
      w_gnt_b = bus.reqB & ~bus.reqA;
    end else begin
      w_gnt_b = bus.reqB & (~bus.reqA | ~r_last_b);
    end
    w_grant     = (r_state == S_IDLE) & w_any_req;
    w_sel_we    = w_gnt_b ? bus.weB    : bus.weA;
    w_sel_addr  = w_gnt_b ? bus.addrB  : bus.addrA;
    w_sel_wdata = w_gnt_b ? bus.wdataB : bus.wdataA;
  end

  // Next-state logic and ramCLK high-phase counter
  always_comb begin
    w_next_state = r_state;
    w_hcnt_nxt   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_SETUP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SETUP: w_next_state = S_HIGH;
      S_HIGH: begin
        if (r_hcnt == HC_LAST) begin
          w_next_state = S_LOW;
        end else begin
          w_next_state = S_HIGH;
          w_hcnt_nxt   = r_hcnt + 4'd1;
        end
      end
      S_LOW:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_hcnt  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // Outputs are registered from the next state so pins line up with the state they describe
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_gnt_b     <= 1'b0;
      r_last_b    <= 1'b1;
      r_ram_addr  <= 8'd0;
      r_ram_wdata <= 16'd0;
      r_ram_we    <= 1'b0;
      r_ram_clk   <= 1'b0;
      r_ram_clken <= 1'b0;
      r_ackA      <= 1'b0;
      r_ackB      <= 1'b0;
      r_busy      <= 1'b0;
      r_rdata     <= 16'd0;
    end else begin
      if (w_grant) begin
        r_gnt_b     <= w_gnt_b;
        r_last_b    <= w_gnt_b;
        r_ram_addr  <= w_sel_addr;
        r_ram_wdata <= w_sel_wdata;
        r_ram_we    <= w_sel_we;
      end else if (r_state == S_LOW) begin
        r_ram_we    <= 1'b0;
      end
      if ((r_state == S_LOW) && !r_ram_we) begin
        r_rdata <= bus.ramReadData;
      end
      r_ram_clk   <= (w_next_state == S_HIGH);
      r_ram_clken <= (w_next_state == S_SETUP) | (w_next_state == S_HIGH) |
                     (w_next_state == S_LOW);
      r_ackA      <= (w_next_state == S_DONE) & ~r_gnt_b;
      r_ackB      <= (w_next_state == S_DONE) &  r_gnt_b;
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  assign bus.ackA         = r_ackA;
  assign bus.ackB         = r_ackB;
  assign bus.rdata        = r_rdata;
  assign bus.busy         = r_busy;
  assign bus.ramAddr      = r_ram_addr;
  assign bus.ramWriteData = r_ram_wdata;
  assign bus.ramWriteEn   = r_ram_we;
  assign bus.ramCLK       = r_ram_clk;
  assign bus.ramCLKEn     = r_ram_clken;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] r_conflict_cnt;

  // Saturating count of grants made while both requesters were asking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_conflict_cnt <= 8'd0;
    end else if (w_grant && w_conflict && (r_conflict_cnt != 8'hFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign bus.conflictCount = r_conflict_cnt;
`else
  assign bus.conflictCount = 8'd0;
`endif

endmodule
